// File: rtl/run_detector.sv
// run_detector
//   Tracks the length of the current run of identical bits on a serial input
//   and flags runs that reach RUN_LEN. Depending on i_mode it looks for runs
//   of 1s, runs of 0s, runs of either value, or nothing.
//
// Ports
//   i_clk       system clock; all state changes on the rising edge
//   i_rst       synchronous reset, active-high; priority over i_clear
//   i_x         serial data bit, sampled every rising edge
//   i_mode      00 runs of 1, 01 runs of 0, 10 either value, 11 disabled
//   i_clear     synchronous restart of run tracking; o_det_cnt is kept
//   o_z         level: qualifying run length >= RUN_LEN
//   o_z_pulse   one cycle when a qualifying run length first reaches RUN_LEN
//   o_run_val   bit value of the current run
//   o_run_cnt   length of the current run, saturating at 2^CNT_W-1
//   o_det_cnt   number of o_z_pulse events since reset, wrapping
//
// All outputs are registered; there is no combinational path from i_x.

module run_detector #(
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned DET_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_x,
    input  logic [1:0]       i_mode,
    input  logic             i_clear,
    output logic             o_z,
    output logic             o_z_pulse,
    output logic             o_run_val,
    output logic [CNT_W-1:0] o_run_cnt,
    output logic [DET_W-1:0] o_det_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun1 = 2'b01,
        StRun0 = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] RunLenC = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           r_state,   w_state_d;
    logic [CNT_W-1:0] r_run_cnt, w_run_cnt_d;
    logic             r_run_val, w_run_val_d;
    logic             r_z,       w_z_d;
    logic             r_z_pulse, w_z_pulse_d;
    logic [DET_W-1:0] r_det_cnt, w_det_cnt_d;
    logic             w_advance;  // count incremented or restarted on this edge
    logic             w_qual;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_run_cnt <= '0;
            r_run_val <= 1'b0;
            r_z       <= 1'b0;
            r_z_pulse <= 1'b0;
            r_det_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_run_cnt <= w_run_cnt_d;
            r_run_val <= w_run_val_d;
            r_z       <= w_z_d;
            r_z_pulse <= w_z_pulse_d;
            r_det_cnt <= w_det_cnt_d;
        end
    end

    // Run tracking
    always_comb begin
        w_state_d   = r_state;
        w_run_cnt_d = r_run_cnt;
        w_run_val_d = r_run_val;
        w_advance   = 1'b0;

        if (i_clear) begin
            // Sample on this edge is discarded; run_val is left as it was.
            w_state_d   = StIdle;
            w_run_cnt_d = '0;
        end else begin
            unique case (r_state)
                StRun1, StRun0: begin
                    if (i_x == (r_state == StRun1)) begin
                        // Saturated runs hold without advancing, so no re-pulse.
                        if (r_run_cnt != CntMax) begin
                            w_run_cnt_d = r_run_cnt + CntOne;
                            w_advance   = 1'b1;
                        end
                    end else begin
                        w_run_cnt_d = CntOne;
                        w_run_val_d = i_x;
                        w_state_d   = i_x ? StRun1 : StRun0;
                        w_advance   = 1'b1;
                    end
                end
                default: begin
                    w_run_cnt_d = CntOne;
                    w_run_val_d = i_x;
                    w_state_d   = i_x ? StRun1 : StRun0;
                    w_advance   = 1'b1;
                end
            endcase
        end
    end

    // Qualification on next-state values
    always_comb begin
        w_qual = 1'b0;
        unique case (i_mode)
            2'b00:   w_qual = w_run_val_d;
            2'b01:   w_qual = ~w_run_val_d;
            2'b10:   w_qual = 1'b1;
            default: w_qual = 1'b0;
        endcase
    end

    always_comb begin
        w_z_d       = 1'b0;
        w_z_pulse_d = 1'b0;
        if (!i_clear) begin
            w_z_d       = w_qual && (w_run_cnt_d >= RunLenC);
            w_z_pulse_d = w_qual && (w_run_cnt_d == RunLenC) && w_advance;
        end
        w_det_cnt_d = r_det_cnt + {{(DET_W-1){1'b0}}, w_z_pulse_d};
    end

    assign o_z       = r_z;
    assign o_z_pulse = r_z_pulse;
    assign o_run_val = r_run_val;
    assign o_run_cnt = r_run_cnt;
    assign o_det_cnt = r_det_cnt;

endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector
//   Directed vectors with hand-computed expectations. dut uses RUN_LEN = 3,
//   dut1 uses RUN_LEN = 1 for the every-cycle pulse and det_cnt wrap case.

module tb_run_detector;

    logic       clk = 1'b0;
    logic       rst, x, clear;
    logic [1:0] mode;
    logic       z, z_pulse, run_val;
    logic [3:0] run_cnt;
    logic [7:0] det_cnt;

    logic       rst1, x1;
    logic [1:0] mode1;
    logic       z1, z_pulse1, run_val1;
    logic [3:0] run_cnt1;
    logic [7:0] det_cnt1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    run_detector #(.RUN_LEN(3), .CNT_W(4), .DET_W(8)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_x      (x),
        .i_mode   (mode),
        .i_clear  (clear),
        .o_z      (z),
        .o_z_pulse(z_pulse),
        .o_run_val(run_val),
        .o_run_cnt(run_cnt),
        .o_det_cnt(det_cnt)
    );

    run_detector #(.RUN_LEN(1), .CNT_W(4), .DET_W(8)) dut1 (
        .i_clk    (clk),
        .i_rst    (rst1),
        .i_x      (x1),
        .i_mode   (mode1),
        .i_clear  (1'b0),
        .o_z      (z1),
        .o_z_pulse(z_pulse1),
        .o_run_val(run_val1),
        .o_run_cnt(run_cnt1),
        .o_det_cnt(det_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        x   = 1'b0;
        tick();
        x   = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Expected tables, one entry per sample
    logic [9:0] v2_x   = 10'b0110011110;  // MSB first
    logic [9:0] v2_z   = 10'b0000000110;
    logic [9:0] v2_p   = 10'b0000000100;
    int         v2_cnt [10] = '{1, 1, 2, 1, 2, 1, 2, 3, 4, 1};

    logic [6:0] v3_x   = 7'b0001111;
    logic [6:0] v3_z   = 7'b0010011;
    logic [6:0] v3_p   = 7'b0010010;
    int         v3_cnt [7] = '{1, 2, 3, 1, 2, 3, 4};

    initial begin
        int npulse;
        int nzhigh;

        rst   = 1'b1;
        x     = 1'b0;
        clear = 1'b0;
        mode  = 2'b00;
        rst1  = 1'b1;
        x1    = 1'b0;
        mode1 = 2'b10;

        // Reset with x toggling
        do_reset();
        chk("rst_z", z, 0);
        chk("rst_pulse", z_pulse, 0);
        chk("rst_cnt", run_cnt, 0);
        chk("rst_val", run_val, 0);
        chk("rst_det", det_cnt, 0);
        x = 1'b1;
        tick();
        chk("post_rst_cnt", run_cnt, 1);
        chk("post_rst_val", run_val, 1);

        // mode 00, 0110011110
        do_reset();
        mode = 2'b00;
        for (int i = 0; i < 10; i++) begin
            x = v2_x[9-i];
            tick();
            chk($sformatf("m00_z[%0d]", i), z, v2_z[9-i]);
            chk($sformatf("m00_p[%0d]", i), z_pulse, v2_p[9-i]);
            chk($sformatf("m00_cnt[%0d]", i), run_cnt, v2_cnt[i]);
        end
        chk("m00_det", det_cnt, 1);

        // mode 10, 000 then 1111
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 7; i++) begin
            x = v3_x[6-i];
            tick();
            chk($sformatf("m10_z[%0d]", i), z, v3_z[6-i]);
            chk($sformatf("m10_p[%0d]", i), z_pulse, v3_p[6-i]);
            chk($sformatf("m10_cnt[%0d]", i), run_cnt, v3_cnt[i]);
        end
        chk("m10_det", det_cnt, 2);

        // mode 01, 0000, clear, 00
        do_reset();
        mode = 2'b01;
        x    = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("m01_cnt4", run_cnt, 4);
        chk("m01_z4", z, 1);
        chk("m01_det4", det_cnt, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_cnt", run_cnt, 0);
        chk("clr_z", z, 0);
        chk("clr_p", z_pulse, 0);
        chk("clr_val", run_val, 0);
        chk("clr_det", det_cnt, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("aclr_cnt[%0d]", i), run_cnt, i + 1);
            chk($sformatf("aclr_p[%0d]", i), z_pulse, 0);
        end
        chk("aclr_det", det_cnt, 1);

        // Saturation: 20 ones
        do_reset();
        mode   = 2'b00;
        x      = 1'b1;
        npulse = 0;
        nzhigh = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            npulse += int'(z_pulse);
            if (i >= 2) nzhigh += int'(z);
        end
        chk("sat_cnt", run_cnt, 15);
        chk("sat_z", z, 1);
        chk("sat_pulses", npulse, 1);
        chk("sat_zhigh", nzhigh, 18);
        chk("sat_det", det_cnt, 1);

        // Disabled, then enabled on the 5th 1
        do_reset();
        mode   = 2'b11;
        x      = 1'b1;
        npulse = 0;
        nzhigh = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            npulse += int'(z_pulse);
            nzhigh += int'(z);
        end
        chk("dis_pulses", npulse, 0);
        chk("dis_zhigh", nzhigh, 0);
        mode = 2'b00;
        tick();
        chk("late_z", z, 1);
        chk("late_p", z_pulse, 0);
        chk("late_cnt", run_cnt, 5);
        chk("late_det", det_cnt, 0);

        // RUN_LEN = 1, alternating x, mode 10
        rst1   = 1'b0;
        npulse = 0;
        nzhigh = 0;
        for (int i = 0; i < 256; i++) begin
            x1 = i[0];
            tick();
            npulse += int'(z_pulse1);
            nzhigh += int'(z1);
            if (i == 0) chk("rl1_first_cnt", run_cnt1, 1);
            if (i == 254) chk("rl1_det255", det_cnt1, 255);
        end
        chk("rl1_pulses", npulse, 256);
        chk("rl1_zhigh", nzhigh, 256);
        chk("rl1_det_wrap", det_cnt1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
